priority_arbiter_rr: RTL

//  Registered successor of the 2**N-to-N priority encoder. Arbitrates 2**N request lines
//  (interrupt sources, bus masters) with a per-line enable mask, optional sticky pending

---
 rtl/priority_arbiter_rr.sv | 100 ++++++++++
 1 files changed

// File: rtl/priority_arbiter_rr.sv
// Registered request arbiter: sticky/transparent pending latches, per-line mask,
// fixed-priority or round-robin selection, winner offered on a valid/ready port.
module priority_arbiter_rr #(
  parameter int N      = 4,
  parameter bit STICKY = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [(1<<N)-1:0]   req_in,
  input  logic [(1<<N)-1:0]   mask_in,
  input  logic                rr_mode,
  input  logic                grant_ready,
  output logic                grant_valid,
  output logic [N-1:0]        grant_idx,
  output logic [(1<<N)-1:0]   pending_out
);

  localparam int R = 1 << N;

  typedef enum logic [0:0] {IDLE = 1'b0, OFFER = 1'b1} state_t;

  // Handshake: a grant transfers on any edge where grant_valid and grant_ready
  // are both high; once raised, grant_valid/grant_idx hold until that transfer.
  state_t       state;
  logic [R-1:0] pending;
  logic [N-1:0] rr_ptr;

  logic         handshake;
  logic [R-1:0] clr;
  logic [R-1:0] e;
  logic [R-1:0] pending_nxt;
  logic [N-1:0] win;
  logic [N-1:0] scan;
  logic         found;
  logic         any;

  assign handshake   = grant_valid & grant_ready;
  assign clr         = handshake ? ({{(R-1){1'b0}}, 1'b1} << grant_idx) : '0;
  assign e           = pending & mask_in & ~clr;
  assign any         = |e;
  // A request arriving on the bit being cleared keeps that bit set.
  assign pending_nxt = STICKY ? ((pending & ~clr) | req_in) : req_in;
  assign pending_out = pending;

  always_comb begin
    win   = '0;
    scan  = '0;
    found = 1'b0;
    if (rr_mode) begin
      for (int i = 0; i < R; i++) begin
        scan = rr_ptr + N'(i);
        if (!found && e[scan]) begin
          win   = scan;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < R; i++) begin
        if (e[i]) win = N'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      rr_ptr      <= '0;
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      pending <= pending_nxt;
      case (state)
        IDLE: begin
          if (any) begin
            grant_idx   <= win;
            grant_valid <= 1'b1;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (grant_ready) begin
            rr_ptr <= grant_idx + N'(1);
            if (any) begin
              grant_idx <= win;
            end else begin
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
